// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package display_pkg;

  localparam int DEF_N_DIGITS = 4;
  localparam int MAX_DIGITS   = 32;

  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;
  localparam logic                  DP_OFF = 1'b1;

  typedef logic [$clog2(DEF_N_DIGITS)-1:0] digit_idx_t;

endpackage

// File: rtl/seg_refresh_prescaler.sv
// Free-running slot counter 0..CLK_DIV-1; o_slot_wrap marks the last cycle of each slot.
// Counter is registered, wrap flag is decoded from it in the same cycle; never stalls.
module seg_refresh_prescaler #(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_slot_wrap
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt       = r_cnt;
  assign o_slot_wrap = w_wrap;

endmodule

// File: rtl/seg_display_scan.sv
// Scan controller for a common-anode 7-seg bank: double-buffered value, dead-time, zero blanking.
// Outputs registered from next-state of the scan counters (no extra lag); load is always accepted.
module seg_display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int CLK_DIV  = 100000,
  parameter int DEAD_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [3:0]            nibble,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int DW    = $clog2(N_DIGITS);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [N_DIGITS-1:0] AN_ALL_OFF = AN_OFF[N_DIGITS-1:0];

  logic [CNT_W-1:0]      w_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_slot_wrap;

  logic [DW-1:0]         r_digit;
  logic [DW-1:0]         w_digit_nxt;
  logic                  w_frame_wrap;

  logic [4*N_DIGITS-1:0] r_pend_data;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic                  r_pend_v;
  logic [4*N_DIGITS-1:0] r_shown_data;
  logic [N_DIGITS-1:0]   r_shown_dp;
  logic [4*N_DIGITS-1:0] w_shown_data_nxt;
  logic [N_DIGITS-1:0]   w_shown_dp_nxt;

  logic                  w_dead;
  logic                  w_zero_run;
  logic [N_DIGITS-1:0]   w_blank;
  logic [3:0]            w_nib_nxt;
  logic [N_DIGITS-1:0]   w_an_nxt;
  logic                  w_dp_nxt;

  logic [3:0]            r_nibble;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_dp;
  logic                  r_frame_tick;

  seg_refresh_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .i_clk       (clk),
    .i_rst       (reset),
    .o_cnt       (w_cnt),
    .o_slot_wrap (w_slot_wrap)
  );

  // Scan position after this edge; everything below is decoded from it.
  assign w_cnt_nxt    = w_slot_wrap ? '0 : (w_cnt + CNT_W'(1));
  assign w_frame_wrap = w_slot_wrap && (r_digit == DW'(N_DIGITS - 1));

  always_comb begin
    w_digit_nxt = r_digit;
    if (w_slot_wrap) begin
      w_digit_nxt = w_frame_wrap ? '0 : (r_digit + DW'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit <= '0;
    end else begin
      r_digit <= w_digit_nxt;
    end
  end

  // A load on the frame edge itself bypasses the pending buffer.
  always_comb begin
    w_shown_data_nxt = r_shown_data;
    w_shown_dp_nxt   = r_shown_dp;
    if (w_frame_wrap) begin
      if (load) begin
        w_shown_data_nxt = data;
        w_shown_dp_nxt   = dp_in;
      end else if (r_pend_v) begin
        w_shown_data_nxt = r_pend_data;
        w_shown_dp_nxt   = r_pend_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_v     <= 1'b0;
      r_shown_data <= '0;
      r_shown_dp   <= '0;
    end else begin
      if (load) begin
        r_pend_data <= data;
        r_pend_dp   <= dp_in;
      end
      if (w_frame_wrap) begin
        r_pend_v <= 1'b0;
      end else if (load) begin
        r_pend_v <= 1'b1;
      end
      r_shown_data <= w_shown_data_nxt;
      r_shown_dp   <= w_shown_dp_nxt;
    end
  end

  // Digit i>0 is blanked when it and every more-significant nibble are zero.
  always_comb begin
    w_blank    = '0;
    w_zero_run = lz_en;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (w_shown_data_nxt[4*i +: 4] == 4'h0);
      w_blank[i] = w_zero_run;
    end
  end

  assign w_dead = (int'(w_cnt_nxt) < DEAD_CYC);

  always_comb begin
    w_nib_nxt = 4'h0;
    w_an_nxt  = AN_ALL_OFF;
    w_dp_nxt  = DP_OFF;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_digit_nxt == DW'(i)) begin
        w_nib_nxt = w_shown_data_nxt[4*i +: 4];
        if (!w_dead && !w_blank[i]) begin
          w_an_nxt[i] = 1'b0;
          w_dp_nxt    = ~w_shown_dp_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nibble     <= 4'h0;
      r_an         <= AN_ALL_OFF;
      r_dp         <= DP_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_nibble     <= w_nib_nxt;
      r_an         <= w_an_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_tick <= w_frame_wrap;
    end
  end

  assign nibble     = r_nibble;
  assign an         = r_an;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
